// File: rtl/gol_pkg.sv
// Shared types and defaults for the Game-of-Life generation scheduler.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    BUSY      = 2'd2,
    SWAP_WAIT = 2'd3
  } genState_t;

  localparam logic GEN_EVOLVE = 1'b0;
  localparam logic GEN_CLEAR  = 1'b1;

  localparam int unsigned DEFAULT_SPEED_W        = 6;
  localparam int unsigned DEFAULT_GEN_CNT_W      = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2000000;

endpackage

// File: rtl/gol_mem_arbiter.sv
// Registered two-requester cell-memory arbiter; the display reader has fixed priority.
module gol_mem_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic dispReq,
  input  logic engReq,
  output logic dispGnt,
  output logic engGnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispGnt <= 1'b0;
      engGnt  <= 1'b0;
    end else begin
      dispGnt <= dispReq;
      engGnt  <= engReq & ~dispReq;
    end
  end

endmodule

// File: rtl/gol_generation_scheduler.sv
// Schedules Game-of-Life generations against VGA vertical blanking and swaps buffers in blanking.
// Optional engine watchdog enabled by defining GOL_GEN_TIMEOUT_EN.
module gol_generation_scheduler
  import gol_pkg::*;
#(
  parameter int unsigned SPEED_W        = DEFAULT_SPEED_W,
  parameter int unsigned GEN_CNT_W      = DEFAULT_GEN_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 systemClk_125MHz,
  input  logic                 rst,
  input  logic                 vBlank,
  input  logic                 runEn,
  input  logic                 stepReq,
  input  logic                 clearReq,
  input  logic [SPEED_W-1:0]   speed,
  output logic                 genStart,
  output logic                 genMode,
  input  logic                 genDone,
  output logic                 frontSel,
  output logic [GEN_CNT_W-1:0] genCount,
  output logic                 busy,
  input  logic                 dispReq,
  input  logic                 engReq,
  output logic                 dispGnt,
  output logic                 engGnt,
  output logic                 errFlag
);

  localparam int unsigned DivW = SPEED_W + 1;

  genState_t          state;
  genState_t          stateNext;
  logic               vbPrev;
  logic               vbEdge;
  logic [SPEED_W-1:0] frameCnt;
  logic               clearPend;
  logic               stepPend;
  logic               clearAny;
  logic               stepAny;
  logic [DivW-1:0]    speedEff;
  logic               divHit;
  logic               trigger;
  logic               trigMode;
  logic               timeoutHit;

  assign vbEdge   = vBlank & ~vbPrev;
  assign clearAny = clearPend | clearReq;
  assign stepAny  = stepPend | stepReq;
  assign speedEff = (speed == '0) ? DivW'(1) : DivW'(speed);
  assign divHit   = runEn & vbEdge & ((DivW'(frameCnt) + DivW'(1)) >= speedEff);

`ifdef GOL_GEN_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [ToW-1:0] toCnt;

  // Watchdog counts BUSY cycles; a genDone on the limit cycle still wins.
  assign timeoutHit = (state == BUSY) && !genDone && (toCnt == ToW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge systemClk_125MHz or negedge rst) begin
    if (!rst) begin
      toCnt   <= '0;
      errFlag <= 1'b0;
    end else begin
      if (state != BUSY) begin
        toCnt <= '0;
      end else if (!timeoutHit) begin
        toCnt <= toCnt + ToW'(1);
      end
      if (timeoutHit) begin
        errFlag <= 1'b1;
      end
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign errFlag    = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    trigger   = 1'b0;
    trigMode  = GEN_EVOLVE;
    case (state)
      IDLE: begin
        if (clearAny) begin
          trigger   = 1'b1;
          trigMode  = GEN_CLEAR;
          stateNext = START;
        end else if (stepAny || divHit) begin
          trigger   = 1'b1;
          stateNext = START;
        end
      end
      START: stateNext = BUSY;
      BUSY: begin
        if (genDone) begin
          stateNext = SWAP_WAIT;
        end else if (timeoutHit) begin
          stateNext = IDLE;
        end
      end
      SWAP_WAIT: begin
        if (vbEdge) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge systemClk_125MHz or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      vbPrev   <= 1'b0;
      genStart <= 1'b0;
      genMode  <= GEN_EVOLVE;
      busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      vbPrev   <= vBlank;
      genStart <= trigger;
      busy     <= (stateNext != IDLE);
      if (trigger) begin
        genMode <= trigMode;
      end
    end
  end

  // Frame divider only advances while idling in free-run mode.
  always_ff @(posedge systemClk_125MHz or negedge rst) begin
    if (!rst) begin
      frameCnt <= '0;
    end else if (trigger || !runEn || clearReq) begin
      frameCnt <= '0;
    end else if ((state == IDLE) && vbEdge) begin
      frameCnt <= frameCnt + SPEED_W'(1);
    end
  end

  // Single-entry request latches; a clear always supersedes a step.
  always_ff @(posedge systemClk_125MHz or negedge rst) begin
    if (!rst) begin
      clearPend <= 1'b0;
      stepPend  <= 1'b0;
    end else if (trigger) begin
      clearPend <= 1'b0;
      stepPend  <= 1'b0;
    end else if (clearReq) begin
      clearPend <= 1'b1;
      stepPend  <= 1'b0;
    end else if (stepReq && !clearPend) begin
      stepPend <= 1'b1;
    end
  end

  // Buffer swap and generation bookkeeping happen only at the start of blanking.
  always_ff @(posedge systemClk_125MHz or negedge rst) begin
    if (!rst) begin
      frontSel <= 1'b0;
      genCount <= '0;
    end else if ((state == SWAP_WAIT) && vbEdge) begin
      frontSel <= ~frontSel;
      genCount <= (genMode == GEN_CLEAR) ? '0 : genCount + GEN_CNT_W'(1);
    end
  end

  gol_mem_arbiter u_arb (
    .clk     (systemClk_125MHz),
    .rst_n   (rst),
    .dispReq (dispReq),
    .engReq  (engReq),
    .dispGnt (dispGnt),
    .engGnt  (engGnt)
  );

endmodule
